// File: rtl/y_cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU op codes and the issue bundle
// handed from the operand stage to the ALU.
package y_cpu_pkg;

    localparam int WIDTH     = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic [WIDTH-1:0]     a;
        logic [WIDTH-1:0]     b;
        logic [2:0]           op;
        logic [REG_IDX_W-1:0] rd;
    } issue_t;

endpackage

// File: rtl/y_reg_file.sv
// Architectural register file: two combinational read ports with write-back
// bypass, one synchronous write port, x0 hardwired to zero.
module y_reg_file
    import y_cpu_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int WIDTH = y_cpu_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] ra1,
    input  logic [REG_IDX_W-1:0] ra2,
    output logic [WIDTH-1:0]     rd1,
    output logic [WIDTH-1:0]     rd2,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] wa,
    input  logic [WIDTH-1:0]     wd
);

    logic [WIDTH-1:0] regs [NREG];
    logic             wr_live;

    assign wr_live = we && (wa != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wa] <= wd;
        end
    end

    // Same-cycle write-back is forwarded so a consumer sees the new value at once.
    always_comb begin
        rd1 = '0;
        if (ra1 != '0) begin
            rd1 = (wr_live && (wa == ra1)) ? wd : regs[ra1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (ra2 != '0) begin
            rd2 = (wr_live && (wa == ra2)) ? wd : regs[ra2];
        end
    end

endmodule

// File: rtl/y_operand_stage.sv
// Issue stage ahead of the ALU: register read, immediate select, pending-write
// scoreboard with RAW/WAW stall, and the registered a/b/op/rd bundle.
module y_operand_stage
    import y_cpu_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int WIDTH = y_cpu_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rs1,
    input  logic [REG_IDX_W-1:0] in_rs2,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [WIDTH-1:0]     in_imm,
    input  logic                 in_use_imm,
    input  logic [2:0]           in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_a,
    output logic [WIDTH-1:0]     out_b,
    output logic [2:0]           out_op,
    output logic [REG_IDX_W-1:0] out_rd,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [WIDTH-1:0]     wb_data
);

    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;
    logic [NREG-1:0]  pending;
    logic [NREG-1:0]  pending_nxt;
    logic             hz1, hz2, hzd, hazard;
    logic             accept;
    logic             out_valid_q;
    issue_t           out_q;

    y_reg_file #(
        .NREG  (NREG),
        .WIDTH (WIDTH)
    ) u_reg_file (
        .clk   (clk),
        .reset (reset),
        .ra1   (in_rs1),
        .ra2   (in_rs2),
        .rd1   (rs1_val),
        .rd2   (rs2_val),
        .we    (wb_en),
        .wa    (wb_rd),
        .wd    (wb_data)
    );

    // A write-back landing this cycle releases its register immediately.
    assign hz1    = pending[in_rs1] && !(wb_en && (wb_rd == in_rs1));
    assign hz2    = !in_use_imm && pending[in_rs2] && !(wb_en && (wb_rd == in_rs2));
    assign hzd    = (in_rd != '0) && pending[in_rd] && !(wb_en && (wb_rd == in_rd));
    assign hazard = hz1 | hz2 | hzd;

    assign in_ready = !reset && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Set is applied after clear so a new issue to rd wins over its own retire.
    always_comb begin
        pending_nxt = pending;
        if (wb_en && (wb_rd != '0)) begin
            pending_nxt[wb_rd] = 1'b0;
        end
        if (accept && (in_rd != '0)) begin
            pending_nxt[in_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            pending <= pending_nxt;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_q.a     <= rs1_val;
                out_q.b     <= in_use_imm ? in_imm : rs2_val;
                out_q.op    <= in_op;
                out_q.rd    <= in_rd;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_q.a;
    assign out_b     = out_q.b;
    assign out_op    = out_q.op;
    assign out_rd    = out_q.rd;

endmodule

// File: tb/tb_y_operand_stage.sv
// Scoreboard bench for y_operand_stage: directed scenarios then random traffic
// against an architectural model of registers, pending writes and the output slot.
module tb_y_operand_stage;
    import y_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic [31:0] in_imm = '0;
    logic        in_use_imm = 1'b0;
    logic [2:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_a, out_b;
    logic [2:0]  out_op;
    logic [4:0]  out_rd;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mreg  [32];
    bit          mpend [32];
    bit          mov;
    issue_t      expq [$];
    issue_t      held;
    bit          hold_v;

    y_operand_stage #(.NREG(32), .WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_rd(out_rd),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rdv(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (wb_en && wb_rd == r) return wb_data;
        return mreg[r];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mreg[i]  = '0;
            mpend[i] = 1'b0;
        end
        mov    = 1'b0;
        hold_v = 1'b0;
        expq.delete();
    endtask

    // Called at posedge+1; presents one cycle of inputs and advances the model.
    task automatic step(input bit iv, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [31:0] imm, input bit ui,
                        input logic [2:0] op, input bit ordy, input bit we,
                        input logic [4:0] wr, input logic [31:0] wd);
        bit     stall, exp_ready, acc;
        issue_t e;
        in_valid = iv; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_imm = imm;
        in_use_imm = ui; in_op = op; out_ready = ordy;
        wb_en = we; wb_rd = wr; wb_data = wd;
        @(negedge clk); #1;
        stall = (mpend[r1] && !(we && wr == r1))
              || (!ui && mpend[r2] && !(we && wr == r2))
              || (rd != 0 && mpend[rd] && !(we && wr == rd));
        exp_ready = !stall && (!mov || ordy);
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        acc = iv && exp_ready;
        if (acc) begin
            e.a  = rdv(r1);
            e.b  = ui ? imm : rdv(r2);
            e.op = op;
            e.rd = rd;
            expq.push_back(e);
        end
        if (we && wr != 0) begin
            mreg[wr]  = wd;
            mpend[wr] = 1'b0;
        end
        if (acc && rd != 0) mpend[rd] = 1'b1;
        if (acc) mov = 1'b1;
        else if (ordy) mov = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, ALU_AND, 1, 0, 0, 0);
    endtask

    task automatic pulse_reset();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_use_imm = 0;
        wb_en = 0; out_ready = 1;
        reset = 1'b1;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_a", out_a, 32'h0);
        chk("rst_out_b", out_b, 32'h0);
        chk("rst_out_op_rd", {24'b0, out_op, out_rd}, 32'h0);
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("post_rst_out_valid", {31'b0, out_valid}, 32'h0);
    endtask

    always @(negedge clk) begin
        issue_t cur, e;
        if (!reset) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, mov});
            if (out_valid) begin
                cur = '{a: out_a, b: out_b, op: out_op, rd: out_rd};
                if (hold_v) chk("hold_stable", {31'b0, cur == held}, 32'h1);
                if (out_ready) begin
                    hold_v = 1'b0;
                    if (expq.size() == 0) begin
                        chk("unexpected_bundle", 32'h1, 32'h0);
                    end else begin
                        e = expq.pop_front();
                        chk("out_a", out_a, e.a);
                        chk("out_b", out_b, e.b);
                        chk("out_op", {29'b0, out_op}, {29'b0, e.op});
                        chk("out_rd", {27'b0, out_rd}, {27'b0, e.rd});
                    end
                end else begin
                    held   = cur;
                    hold_v = 1'b1;
                end
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin
        logic [4:0]  r1, r2, rd, wr;
        logic [31:0] imm;
        bit          we;
        model_clear();
        @(posedge clk); #1;
        pulse_reset();

        // reset mid-operation with x5 pending
        step(1, 0, 0, 5, 0, 0, ALU_ADD, 1, 0, 0, 0);
        pulse_reset();
        step(1, 5, 0, 0, 0, 0, ALU_ADD, 1, 0, 0, 0);
        idle();

        // write then read
        step(0, 0, 0, 0, 0, 0, ALU_AND, 1, 1, 3, 32'h0000_0007);
        step(1, 3, 0, 0, 0, 0, ALU_ADD, 1, 0, 0, 0);
        idle();

        // immediate bypasses a pending rs2, then RAW stall released by write-back
        step(1, 0, 0, 4, 0, 0, ALU_ADD, 1, 0, 0, 0);
        step(1, 0, 4, 0, 32'hFFFF_FFF0, 1, ALU_SUB, 1, 0, 0, 0);
        repeat (3) step(1, 4, 0, 0, 0, 0, ALU_OR, 1, 0, 0, 0);
        step(1, 4, 0, 0, 0, 0, ALU_OR, 1, 1, 4, 32'h0000_1234);
        idle();

        // backpressure
        step(1, 3, 0, 7, 0, 0, ALU_SLT, 1, 0, 0, 0);
        repeat (3) step(1, 3, 3, 8, 0, 0, ALU_AND, 0, 0, 0, 0);
        step(1, 3, 3, 8, 0, 0, ALU_AND, 1, 0, 0, 0);
        idle();

        // x0 write ignored; WAW on x6
        step(0, 0, 0, 0, 0, 0, ALU_AND, 1, 1, 0, 32'h0000_DEAD);
        step(1, 0, 0, 0, 0, 0, ALU_ADD, 1, 0, 0, 0);
        step(1, 0, 0, 6, 0, 0, ALU_ADD, 1, 0, 0, 0);
        repeat (2) step(1, 0, 0, 6, 0, 0, ALU_ADD, 1, 0, 0, 0);
        step(1, 0, 0, 6, 0, 0, ALU_ADD, 1, 1, 6, 32'h0000_0066);
        idle();

        // random traffic over a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            r1  = 5'($urandom_range(0, 7));
            r2  = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            imm = $urandom;
            we  = ($urandom_range(0, 2) != 0);
            wr  = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 8; k++) begin
                    if (mpend[k]) wr = 5'(k);
                end
            end
            step($urandom_range(0, 3) != 0, r1, r2, rd, imm, $urandom_range(0, 3) == 0,
                 3'($urandom_range(0, 7)), $urandom_range(0, 9) < 7, we, wr, $urandom);
        end

        repeat (4) idle();
        chk("queue_empty", expq.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/y_operand_stage.md
Name: y_operand_stage

Overview:
- Issue stage directly upstream of the CPU ALU (yAlu).
- Holds the 32x32 architectural register file and reads rs1/rs2, selecting the immediate for B when requested.
- Registers a, b, op and rd toward the ALU behind a valid/ready handshake.
- A per-register pending scoreboard, with write-back bypass, stalls issue on RAW and WAW hazards until the producing result returns on the write-back port.

Parameters:
- NREG, 32, number of architectural registers; index width is 5, and NREG must be 32.
- WIDTH, 32, datapath width; must match the ALU a/b/z width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage accepts the instruction this cycle.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_rd  input  5  destination register; 0 means no write-back.
- in_imm  input  WIDTH  sign-extended immediate.
- in_use_imm  input  1  1 means B = in_imm; rs2 is then ignored for hazards.
- in_op  input  3  ALU op code, passed through unchanged.
- out_valid  output  1  out_* bundle valid toward the ALU.
- out_ready  input  1  downstream accepts the bundle.
- out_a  output  WIDTH  operand A.
- out_b  output  WIDTH  operand B.
- out_op  output  3  ALU op.
- out_rd  output  5  destination, forwarded for write-back.
- wb_en  input  1  write-back strobe.
- wb_rd  input  5  write-back register.
- wb_data  input  WIDTH  write-back value.

Behaviour:
- Reset (asynchronous, active-high):
  - out_valid=0; out_a, out_b = 0; out_op, out_rd = 0.
  - All pending bits = 0; all registers = 0.
  - in_ready is combinational and is 0 while reset is asserted.
  - Reset mid-operation discards any held bundle and all outstanding pending bits.
- Register file:
  - x0 always reads 0.
  - Writes to x0 are ignored and never set or clear pending[0].
- Write-back, on a clk edge when wb_en=1 and wb_rd!=0:
  - reg[wb_rd] <= wb_data.
  - pending[wb_rd] <= 0, unless the set rule below also applies to the same register in the same cycle.
- Read bypass:
  - If wb_en=1, wb_rd!=0 and wb_rd==rs in the same cycle, the read returns wb_data rather than the stale register value.
  - This gives 0-cycle write-to-read latency.
- Hazard, combinational:
  - Let cleared(r) = wb_en && wb_rd==r.
  - hz1 = pending[rs1] && !cleared(rs1).
  - hz2 = !in_use_imm && pending[rs2] && !cleared(rs2).
  - hzd = in_rd!=0 && pending[in_rd] && !cleared(in_rd). This is the WAW guard, since only one outstanding write per register is allowed.
  - hazard = hz1 | hz2 | hzd.
- Handshake:
  - in_ready = !reset && !hazard && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
  - On accept, the output registers load on the next edge: out_a = rd(rs1), out_b = in_use_imm ? in_imm : rd(rs2), out_op = in_op, out_rd = in_rd, out_valid = 1.
  - Issue latency is 1 cycle.
  - Else if out_ready=1, out_valid <= 0.
  - Otherwise out_* hold stable; out_* must never change while out_valid && !out_ready.
- Throughput is one instruction per cycle when hazard-free and the downstream is always ready.
- Scoreboard set: on accept with in_rd!=0, pending[in_rd] <= 1. Set wins over a same-cycle clear of the same register.
- in_valid=0 never changes state other than write-back and draining out_valid.
- Write-back to a non-pending register is legal: data is written and the pending bit stays 0.

Decomposition:
- Shared package y_cpu_pkg holds:
  - WIDTH=32 and REG_IDX_W=5.
  - The 3-bit ALU op constants: AND=000, OR=001, ADD=010, SUB=110, SLT=111.
  - A struct type for the issue bundle {a, b, op, rd}.
- One sub-module, y_reg_file: 32xWIDTH, two combinational read ports with write-back bypass, one synchronous write port, and x0 hardwired to zero.
- Scoreboard, hazard logic and the output register stay in y_operand_stage.

Test Plan:
- Reset mid-operation:
  - Stimulus: issue rd=5 so pending[5]=1, then pulse reset.
  - Required: out_valid=0 and in_ready=1 after release; an instruction with rs1=5 issues immediately with out_a=0.
- Write then read:
  - Stimulus: wb x3=0x0000_0007, next cycle issue rs1=3, rs2=0, use_imm=0, op=010.
  - Required: one cycle later out_a=7, out_b=0, out_op=010, out_valid=1.
- RAW stall and bypass:
  - Stimulus: issue rd=4; then present rs1=4.
  - Required: in_ready=0 until wb_en, wb_rd=4, wb_data=0x1234 arrives. In that same cycle in_ready=1, and next cycle out_a=0x1234.
- Immediate:
  - Stimulus: rs2=4 pending, use_imm=1, imm=0xFFFF_FFF0, rs1=0.
  - Required: no stall; out_b=0xFFFF_FFF0.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with in_valid=1.
  - Required: out_* hold stable, in_ready=0, and exactly one bundle is delivered per out_ready handshake with no loss or duplication.
- x0 and WAW:
  - Stimulus: wb x0=0xDEAD.
  - Required: read x0 returns 0.
  - Stimulus: issue rd=6 twice back to back.
  - Required: the second stalls until the wb for x6 arrives.
